// File: rtl/seg_pkg.sv
// Shared constants and code-to-segment decode for the seven-segment scan driver.
// Segment byte layout: bit 7..0 = a,b,c,d,e,f,g,dp, active-high.
package seg_pkg;

  localparam int CODE_W = 4;
  localparam int SEG_W  = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 8'hFC;
  localparam logic [SEG_W-1:0] SEG_1     = 8'h60;
  localparam logic [SEG_W-1:0] SEG_2     = 8'hDA;
  localparam logic [SEG_W-1:0] SEG_3     = 8'hF2;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 8'hB6;
  localparam logic [SEG_W-1:0] SEG_6     = 8'hBE;
  localparam logic [SEG_W-1:0] SEG_7     = 8'hE0;
  localparam logic [SEG_W-1:0] SEG_8     = 8'hFE;
  localparam logic [SEG_W-1:0] SEG_9     = 8'hF6;
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'h02;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  localparam logic [CODE_W-1:0] CODE_DASH = 4'hF;

  // Codes A..E have no glyph and render blank; F is the separator dash.
  function automatic logic [SEG_W-1:0] code_to_seg(input logic [CODE_W-1:0] code);
    logic [SEG_W-1:0] seg;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational wrapper around code_to_seg; one instance sits on the muxed slot code.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SEG_W-1:0]  seg_o
);

  assign seg_o = code_to_seg(code_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for two 4-digit seven-segment groups with per-slot dead time.
// Optional digit blinking is built only when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int DEAD_CYC  = 16,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] time_data,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  tube_sel
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_DEAD = PRE_W'(DEAD_CYC);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       snap_q, snap_d;
  logic              boot_q;
  logic [7:0]        digit1_d, digit2_d, tube_sel_d;

  logic              pre_wrap, frame_wrap, dead, blank;
  logic [2:0]        tube;
  logic [31:0]       snap_view;
  logic [CODE_W-1:0] cur_code;
  logic [SEG_W-1:0]  dec_seg, pat;

  assign pre_wrap   = (pre_q == PRE_LAST);
  assign frame_wrap = pre_wrap && (idx_q == 3'd7);
  assign dead       = (pre_q < PRE_DEAD);
  assign tube       = ~idx_q;

  // The first cycle after reset reads time_data directly so slot 0 never shows a stale snapshot.
  assign snap_view = boot_q ? time_data : snap_q;
  assign cur_code  = snap_view[{tube, 2'b00} +: CODE_W];

  always_comb begin
    pre_d  = pre_wrap ? '0 : pre_q + 1'b1;
    idx_d  = pre_wrap ? idx_q + 3'd1 : idx_q;
    snap_d = snap_q;
    if (boot_q || frame_wrap) snap_d = time_data;
  end

  seg_decoder u_dec (
    .code_i (cur_code),
    .seg_o  (dec_seg)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q + 1'b1;
    phase_d   = phase_q;
    if (blk_cnt_q == BLK_LAST) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
    end
  end

  // Mask is applied live so blink selection responds within the current frame.
  assign blank = phase_q & blink_mask[tube];
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ (BLINK_DIV > 0);
  assign blank        = 1'b0;
`endif

  assign pat = blank ? SEG_BLANK : dec_seg;

  always_comb begin
    tube_sel_d = 8'h00;
    digit1_d   = 8'h00;
    digit2_d   = 8'h00;
    if (!dead) begin
      tube_sel_d = 8'h01 << tube;
      if (tube[2]) digit1_d = pat;
      else         digit2_d = pat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q    <= '0;
      idx_q    <= '0;
      snap_q   <= '0;
      boot_q   <= 1'b1;
      digit1   <= 8'h00;
      digit2   <= 8'h00;
      tube_sel <= 8'h00;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      boot_q   <= 1'b0;
      digit1   <= digit1_d;
      digit2   <= digit2_d;
      tube_sel <= tube_sel_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed scoreboard bench for seg_scan_driver (SCAN_DIV=8, DEAD_CYC=2, BLINK_DIV=64).
module tb_seg_scan_driver;

  localparam int SCAN_DIV  = 8;
  localparam int DEAD_CYC  = 2;
  localparam int BLINK_DIV = 64;
  localparam int FRAME     = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] time_data = 32'h0;
  logic [7:0]  blink_mask = 8'h00;
  logic [7:0]  digit1, digit2, tube_sel;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] sb_q[$];

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .DEAD_CYC  (DEAD_CYC),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .time_data  (time_data),
    .blink_mask (blink_mask),
    .digit1     (digit1),
    .digit2     (digit2),
    .tube_sel   (tube_sel)
  );

  function automatic logic [7:0] ref_seg(input logic [3:0] c);
    case (c)
      4'h0: return 8'hFC;
      4'h1: return 8'h60;
      4'h2: return 8'hDA;
      4'h3: return 8'hF2;
      4'h4: return 8'h66;
      4'h5: return 8'hB6;
      4'h6: return 8'hBE;
      4'h7: return 8'hE0;
      4'h8: return 8'hFE;
      4'h9: return 8'hF6;
      4'hF: return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  // Expected {tube_sel, digit1, digit2} for frame-relative cycle c.
  function automatic logic [23:0] ref_out(input int c, input logic [31:0] d,
                                          input bit ph, input logic [7:0] m);
    int          slot;
    int          pre;
    int          tb_tube;
    logic [7:0]  pat;
    logic [7:0]  ts;
    slot = (c / SCAN_DIV) % 8;
    pre  = c % SCAN_DIV;
    if (pre < DEAD_CYC) return 24'h0;
    tb_tube = 7 - slot;
    pat = ref_seg(d[4*tb_tube +: 4]);
    if (ph && m[tb_tube]) pat = 8'h00;
    ts = 8'h01 << tb_tube;
    if (tb_tube >= 4) return {ts, pat, 8'h00};
    return {ts, 8'h00, pat};
  endfunction

  task automatic push_frame(input logic [31:0] d, input logic [7:0] m, input int fidx);
    bit ph;
    for (int c = 0; c < FRAME; c++) begin
      ph = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
      ph = (((fidx * FRAME + c) / BLINK_DIV) % 2) == 1;
`endif
      sb_q.push_back(ref_out(c, d, ph, m));
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tube_sel"}, tube_sel, 8'h00);
    chk({tag, "_digit1"}, digit1, 8'h00);
    chk({tag, "_digit2"}, digit2, 8'h00);
  endtask

  task automatic run_cycles(input int n);
    logic [23:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_underflow observed=empty expected=entry");
      end else begin
        e = sb_q.pop_front();
        chk("tube_sel", tube_sel, e[23:16]);
        chk("digit1", digit1, e[15:8]);
        chk("digit2", digit2, e[7:0]);
      end
    end
  endtask

  initial begin
    // Reset held with all-dash data: outputs must stay cleared.
    time_data = 32'hFFFF_FFFF;
    #2 rst = 1'b0;
    #1 chk_zero("reset_async");
    repeat (4) begin
      @(negedge clk);
      chk_zero("reset_hold");
    end

    // Frame 0 after release, then a frame torn mid-idx-3 by a data change.
    time_data = 32'h12F3_4F56;
    rst = 1'b1;
    push_frame(32'h12F3_4F56, 8'h00, 0);
    run_cycles(FRAME);
    push_frame(32'h12F3_4F56, 8'h00, 1);
    run_cycles(3 * SCAN_DIV + 4);
    time_data = 32'h99F9_9F99;
    run_cycles(FRAME - (3 * SCAN_DIV + 4));

    // New data appears in the following frame; reset is asserted during idx 5.
    push_frame(32'h99F9_9F99, 8'h00, 2);
    run_cycles(5 * SCAN_DIV + 3);
    rst = 1'b0;
    #1 chk_zero("reset_mid");
    sb_q.delete();
    time_data = 32'h8765_4321;
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset_mid_hold");
    end
`ifndef SEG_SCAN_BLINK_EN
    blink_mask = 8'hFF;
`endif
    rst = 1'b1;
    push_frame(32'h8765_4321, blink_mask, 0);
    run_cycles(FRAME);

`ifdef SEG_SCAN_BLINK_EN
    // Blink: tubes 1,0 blank in odd 64-cycle phases; stepping unchanged.
    @(negedge clk);
    rst = 1'b0;
    time_data  = 32'h00F0_0F00;
    blink_mask = 8'h03;
    @(negedge clk);
    rst = 1'b1;
    for (int f = 0; f < 3; f++) begin
      push_frame(32'h00F0_0F00, 8'h03, f);
      run_cycles(FRAME);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
